// File: rtl/ibex_rvfi_replay.sv
// RVFI retirement producer: buffers packed retirement records and replays them
// onto the RVFI signals with one rvfi_valid pulse per record.
module ibex_rvfi_replay #(
    parameter int unsigned Depth     = 4,
    parameter logic [63:0] OrderInit = 64'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     rec_valid_i,
    output logic                     rec_ready_o,
    input  logic [313:0]             rec_i,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic [3:0]               gap_i,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     halted_o,
    output logic                     rvfi_valid,
    output logic [63:0]              rvfi_order,
    output logic [31:0]              rvfi_insn,
    output logic                     rvfi_trap,
    output logic                     rvfi_halt,
    output logic                     rvfi_intr,
    output logic [1:0]               rvfi_mode,
    output logic [1:0]               rvfi_ixl,
    output logic [4:0]               rvfi_rs1_addr,
    output logic [4:0]               rvfi_rs2_addr,
    output logic [4:0]               rvfi_rs3_addr,
    output logic [31:0]              rvfi_rs1_rdata,
    output logic [31:0]              rvfi_rs2_rdata,
    output logic [31:0]              rvfi_rs3_rdata,
    output logic [4:0]               rvfi_rd_addr,
    output logic [31:0]              rvfi_rd_wdata,
    output logic [31:0]              rvfi_pc_rdata,
    output logic [31:0]              rvfi_pc_wdata,
    output logic [31:0]              rvfi_mem_addr,
    output logic [3:0]               rvfi_mem_rmask,
    output logic [3:0]               rvfi_mem_wmask,
    output logic [31:0]              rvfi_mem_rdata,
    output logic [31:0]              rvfi_mem_wdata
);

    localparam int unsigned AW = $clog2(Depth);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        GAP   = 2'b10
    } state_e;

    state_e         state_r, state_s;
    logic [3:0]     gap_cnt_r;
    logic           halted_r;
    logic [AW:0]    wr_ptr_r, rd_ptr_r;
    logic [AW:0]    count_s;
    logic           full_s, empty_s, push_s, pop_s, can_issue_s;
    logic [313:0]   head_s;
    logic [63:0]    order_next_r;
    logic [313:0]   mem_r [Depth];

    assign count_s     = wr_ptr_r - rd_ptr_r;
    assign full_s      = (count_s == (AW+1)'(Depth));
    assign empty_s     = (count_s == {(AW+1){1'b0}});
    assign rec_ready_o = !full_s && !flush_i;
    assign push_s      = rec_valid_i && rec_ready_o;
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
    assign can_issue_s = enable_i && !empty_s && !halted_r && !flush_i;
    assign count_o     = count_s;
    assign halted_o    = halted_r;

    // Issue sequencing: ISSUE and the last GAP cycle may pop directly so no extra idle cycle is inserted.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (can_issue_s) begin
                    pop_s   = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (gap_i != 4'd0) begin
                    state_s = GAP;
                end else if (can_issue_s) begin
                    pop_s   = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_r > 4'd1) begin
                    state_s = GAP;
                end else if (can_issue_s) begin
                    pop_s   = 1'b1;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (flush_i) begin
            state_s = IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // FSM, gap counter, FIFO pointers and sticky halt flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            gap_cnt_r <= 4'd0;
            halted_r  <= 1'b0;
            wr_ptr_r  <= {(AW+1){1'b0}};
            rd_ptr_r  <= {(AW+1){1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == ISSUE) begin
                gap_cnt_r <= gap_i;
            end else if (state_r == GAP && gap_cnt_r != 4'd0) begin
                gap_cnt_r <= gap_cnt_r - 4'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
            if (flush_i) begin
                wr_ptr_r <= {(AW+1){1'b0}};
                rd_ptr_r <= {(AW+1){1'b0}};
                halted_r <= 1'b0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
                    // Set at pop so a halting record can never be followed back-to-back.
                    if (head_s[313]) begin
                        halted_r <= 1'b1;
                    end
                end
            end
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= rec_i;
        end
    end

    // RVFI output registers, loaded from the FIFO head on each pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvfi_valid     <= 1'b0;
            rvfi_order     <= OrderInit;
            order_next_r   <= OrderInit;
            rvfi_insn      <= 32'd0;
            rvfi_trap      <= 1'b0;
            rvfi_halt      <= 1'b0;
            rvfi_intr      <= 1'b0;
            rvfi_mode      <= 2'b00;
            rvfi_ixl       <= 2'b00;
            rvfi_rs1_addr  <= 5'd0;
            rvfi_rs2_addr  <= 5'd0;
            rvfi_rs3_addr  <= 5'd0;
            rvfi_rs1_rdata <= 32'd0;
            rvfi_rs2_rdata <= 32'd0;
            rvfi_rs3_rdata <= 32'd0;
            rvfi_rd_addr   <= 5'd0;
            rvfi_rd_wdata  <= 32'd0;
            rvfi_pc_rdata  <= 32'd0;
            rvfi_pc_wdata  <= 32'd0;
            rvfi_mem_addr  <= 32'd0;
            rvfi_mem_rmask <= 4'd0;
            rvfi_mem_wmask <= 4'd0;
            rvfi_mem_rdata <= 32'd0;
            rvfi_mem_wdata <= 32'd0;
        end else begin
            rvfi_valid <= (state_s == ISSUE);
            if (pop_s) begin
                rvfi_order     <= order_next_r;
                order_next_r   <= order_next_r + 64'd1;
                rvfi_insn      <= head_s[31:0];
                rvfi_pc_rdata  <= head_s[63:32];
                rvfi_pc_wdata  <= head_s[95:64];
                rvfi_rd_wdata  <= (head_s[292:288] == 5'd0) ? 32'd0 : head_s[127:96];
                rvfi_rs1_rdata <= head_s[159:128];
                rvfi_rs2_rdata <= head_s[191:160];
                rvfi_mem_addr  <= head_s[223:192];
                rvfi_mem_rdata <= head_s[255:224];
                rvfi_mem_wdata <= head_s[287:256];
                rvfi_rd_addr   <= head_s[292:288];
                rvfi_rs1_addr  <= head_s[297:293];
                rvfi_rs2_addr  <= head_s[302:298];
                rvfi_mem_rmask <= head_s[306:303];
                rvfi_mem_wmask <= head_s[310:307];
                rvfi_trap      <= head_s[311];
                rvfi_intr      <= head_s[312];
                rvfi_halt      <= head_s[313];
                rvfi_mode      <= 2'b11;
                rvfi_ixl       <= 2'b01;
                rvfi_rs3_addr  <= 5'd0;
                rvfi_rs3_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_ibex_rvfi_replay.sv
// Directed bench for ibex_rvfi_replay; a second instance with OrderInit at
// all-ones covers rvfi_order wrap-around.
module tb_ibex_rvfi_replay;

    logic clk_i = 1'b0;
    logic rst_ni, rec_valid_i, enable_i, flush_i;
    logic [313:0] rec_i;
    logic [3:0]   gap_i;

    logic rec_ready_o, halted_o, rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [2:0] count_o;
    logic [63:0] rvfi_order;
    logic [1:0] rvfi_mode, rvfi_ixl;
    logic [4:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic [3:0] rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;

    logic rec_ready_b, halted_b, valid_b, trap_b, halt_b, intr_b;
    logic [2:0] count_b;
    logic [63:0] order_b;
    logic [1:0] mode_b, ixl_b;
    logic [4:0] rs1_addr_b, rs2_addr_b, rs3_addr_b, rd_addr_b;
    logic [3:0] mem_rmask_b, mem_wmask_b;
    logic [31:0] insn_b, rs1_rdata_b, rs2_rdata_b, rs3_rdata_b, rd_wdata_b;
    logic [31:0] pc_rdata_b, pc_wdata_b, mem_addr_b, mem_rdata_b, mem_wdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ibex_rvfi_replay #(.Depth(4), .OrderInit(64'h0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rec_valid_i(rec_valid_i), .rec_ready_o(rec_ready_o),
        .rec_i(rec_i), .enable_i(enable_i), .flush_i(flush_i), .gap_i(gap_i),
        .count_o(count_o), .halted_o(halted_o), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl), .rvfi_rs1_addr(rvfi_rs1_addr),
        .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rs3_rdata(rvfi_rs3_rdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata)
    );

    ibex_rvfi_replay #(.Depth(4), .OrderInit(64'hFFFF_FFFF_FFFF_FFFF)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .rec_valid_i(rec_valid_i), .rec_ready_o(rec_ready_b),
        .rec_i(rec_i), .enable_i(enable_i), .flush_i(flush_i), .gap_i(gap_i),
        .count_o(count_b), .halted_o(halted_b), .rvfi_valid(valid_b), .rvfi_order(order_b),
        .rvfi_insn(insn_b), .rvfi_trap(trap_b), .rvfi_halt(halt_b), .rvfi_intr(intr_b),
        .rvfi_mode(mode_b), .rvfi_ixl(ixl_b), .rvfi_rs1_addr(rs1_addr_b),
        .rvfi_rs2_addr(rs2_addr_b), .rvfi_rs3_addr(rs3_addr_b),
        .rvfi_rs1_rdata(rs1_rdata_b), .rvfi_rs2_rdata(rs2_rdata_b),
        .rvfi_rs3_rdata(rs3_rdata_b), .rvfi_rd_addr(rd_addr_b), .rvfi_rd_wdata(rd_wdata_b),
        .rvfi_pc_rdata(pc_rdata_b), .rvfi_pc_wdata(pc_wdata_b), .rvfi_mem_addr(mem_addr_b),
        .rvfi_mem_rmask(mem_rmask_b), .rvfi_mem_wmask(mem_wmask_b),
        .rvfi_mem_rdata(mem_rdata_b), .rvfi_mem_wdata(mem_wdata_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [313:0] mk(input logic [31:0] insn, input logic [4:0] rd,
                                        input logic [31:0] wd, input logic halt);
        logic [313:0] r;
        r = {314{1'b0}};
        r[31:0]    = insn;
        r[63:32]   = insn + 32'h100;
        r[95:64]   = insn + 32'h104;
        r[127:96]  = wd;
        r[292:288] = rd;
        r[313]     = halt;
        return r;
    endfunction

    logic [313:0] rec_g;

    initial begin
        rst_ni = 1'b0; rec_valid_i = 1'b0; rec_i = {314{1'b0}};
        enable_i = 1'b0; flush_i = 1'b0; gap_i = 4'd0;
        step(); step();
        chk("reset_valid", 64'(rvfi_valid), 64'd0);
        chk("reset_order", rvfi_order, 64'd0);
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_ready", 64'(rec_ready_o), 64'd1);
        chk("reset_halted", 64'(halted_o), 64'd0);
        chk("reset_order_b", order_b, 64'hFFFF_FFFF_FFFF_FFFF);

        // 1: three back-to-back records
        rst_ni = 1'b1; enable_i = 1'b1;
        rec_valid_i = 1'b1; rec_i = mk(32'h0000_0013, 5'd1, 32'd1, 1'b0);
        step();
        chk("t1_count", 64'(count_o), 64'd1);
        chk("t1_latency", 64'(rvfi_valid), 64'd0);
        rec_i = mk(32'h0010_0093, 5'd1, 32'd2, 1'b0);
        step();
        chk("t1_v0", 64'(rvfi_valid), 64'd1);
        chk("t1_insn0", 64'(rvfi_insn), 64'h0000_0013);
        chk("t1_order0", rvfi_order, 64'd0);
        chk("t1_pc0", 64'(rvfi_pc_rdata), 64'h0000_0113);
        chk("t1_mode", 64'(rvfi_mode), 64'd3);
        chk("t1_ixl", 64'(rvfi_ixl), 64'd1);
        rec_i = mk(32'h0020_8113, 5'd1, 32'd3, 1'b0);
        step();
        chk("t1_v1", 64'(rvfi_valid), 64'd1);
        chk("t1_insn1", 64'(rvfi_insn), 64'h0010_0093);
        chk("t1_order1", rvfi_order, 64'd1);
        rec_valid_i = 1'b0;
        step();
        chk("t1_v2", 64'(rvfi_valid), 64'd1);
        chk("t1_insn2", 64'(rvfi_insn), 64'h0020_8113);
        chk("t1_order2", rvfi_order, 64'd2);
        chk("t1_count_end", 64'(count_o), 64'd0);
        step();
        chk("t1_idle", 64'(rvfi_valid), 64'd0);
        chk("t1_hold", 64'(rvfi_insn), 64'h0020_8113);

        // 2: gap_i=3 spaces pulses 4 cycles apart
        enable_i = 1'b0; gap_i = 4'd3; rec_valid_i = 1'b1;
        rec_i = mk(32'h0031_0193, 5'd3, 32'd4, 1'b0);
        step();
        rec_i = mk(32'h0041_8213, 5'd4, 32'd5, 1'b0);
        step();
        rec_valid_i = 1'b0;
        chk("t2_count2", 64'(count_o), 64'd2);
        enable_i = 1'b1;
        step();
        chk("t2_p0", 64'(rvfi_valid), 64'd1);
        chk("t2_insn0", 64'(rvfi_insn), 64'h0031_0193);
        chk("t2_count1", 64'(count_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_gap", 64'(rvfi_valid), 64'd0);
        end
        step();
        chk("t2_p1", 64'(rvfi_valid), 64'd1);
        chk("t2_insn1", 64'(rvfi_insn), 64'h0041_8213);
        chk("t2_order1", rvfi_order, 64'd4);
        chk("t2_count0", 64'(count_o), 64'd0);
        step(); step(); step(); step();
        gap_i = 4'd0;

        // 3: fill with issue disabled, then drain in order
        enable_i = 1'b0; rec_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rec_i = mk(32'h1000_0000 + 32'(i), 5'd2, 32'd0, 1'b0);
            step();
        end
        rec_valid_i = 1'b0;
        chk("t3_full_count", 64'(count_o), 64'd4);
        chk("t3_ready_low", 64'(rec_ready_o), 64'd0);
        chk("t3_no_issue", 64'(rvfi_valid), 64'd0);
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_valid", 64'(rvfi_valid), 64'd1);
            chk("t3_insn", 64'(rvfi_insn), 64'(32'h1000_0000 + 32'(i)));
            chk("t3_order", rvfi_order, 64'(5 + i));
            chk("t3_count", 64'(count_o), 64'(3 - i));
        end
        step();
        chk("t3_idle", 64'(rvfi_valid), 64'd0);

        // 4: rd_addr=0 normalisation
        rec_g = mk(32'h0000_00B3, 5'd0, 32'hDEAD_BEEF, 1'b0);
        rec_g[311] = 1'b1;
        rec_g[255:224] = 32'hCAFE_F00D;
        rec_valid_i = 1'b1; rec_i = rec_g;
        step();
        rec_i = mk(32'h0000_02B3, 5'd5, 32'h1234_5678, 1'b0);
        step();
        chk("t4_rd0_wdata", 64'(rvfi_rd_wdata), 64'd0);
        chk("t4_rd0_addr", 64'(rvfi_rd_addr), 64'd0);
        chk("t4_trap", 64'(rvfi_trap), 64'd1);
        chk("t4_mem_rdata", 64'(rvfi_mem_rdata), 64'hCAFE_F00D);
        chk("t4_order9", rvfi_order, 64'd9);
        rec_valid_i = 1'b0;
        step();
        chk("t4_rd5_wdata", 64'(rvfi_rd_wdata), 64'h1234_5678);
        chk("t4_rd5_addr", 64'(rvfi_rd_addr), 64'd5);
        chk("t4_trap_clr", 64'(rvfi_trap), 64'd0);
        step();

        // 5: halt then flush
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("t5_reset_order", rvfi_order, 64'd0);
        chk("t5_reset_count", 64'(count_o), 64'd0);
        enable_i = 1'b0; rec_valid_i = 1'b1;
        rec_i = mk(32'h2000_0000, 5'd1, 32'd0, 1'b0); step();
        rec_i = mk(32'h2000_0001, 5'd1, 32'd0, 1'b1); step();
        rec_i = mk(32'h2000_0002, 5'd1, 32'd0, 1'b0); step();
        rec_valid_i = 1'b0;
        chk("t5_count3", 64'(count_o), 64'd3);
        enable_i = 1'b1;
        step();
        chk("t5_p0_insn", 64'(rvfi_insn), 64'h2000_0000);
        chk("t5_p0_halted", 64'(halted_o), 64'd0);
        step();
        chk("t5_p1_valid", 64'(rvfi_valid), 64'd1);
        chk("t5_p1_order", rvfi_order, 64'd1);
        chk("t5_halted", 64'(halted_o), 64'd1);
        step();
        chk("t5_stop_valid", 64'(rvfi_valid), 64'd0);
        step();
        chk("t5_stop_valid2", 64'(rvfi_valid), 64'd0);
        chk("t5_count1", 64'(count_o), 64'd1);
        flush_i = 1'b1;
        #1;
        chk("t5_flush_ready", 64'(rec_ready_o), 64'd0);
        step();
        flush_i = 1'b0;
        chk("t5_flush_count", 64'(count_o), 64'd0);
        chk("t5_flush_halted", 64'(halted_o), 64'd0);
        rec_valid_i = 1'b1; rec_i = mk(32'h3000_0000, 5'd1, 32'd0, 1'b0);
        step();
        rec_valid_i = 1'b0;
        step();
        chk("t5_after_valid", 64'(rvfi_valid), 64'd1);
        chk("t5_after_insn", 64'(rvfi_insn), 64'h3000_0000);
        chk("t5_after_order", rvfi_order, 64'd2);
        step();

        // 6: order wrap and reset during ISSUE
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("t6_reset_valid_b", 64'(valid_b), 64'd0);
        rec_valid_i = 1'b1; rec_i = mk(32'h4000_0000, 5'd1, 32'd0, 1'b0);
        step();
        rec_i = mk(32'h4000_0001, 5'd1, 32'd0, 1'b0);
        step();
        chk("t6_b_valid0", 64'(valid_b), 64'd1);
        chk("t6_b_order_max", order_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t6_a_order0", rvfi_order, 64'd0);
        rec_i = mk(32'h4000_0002, 5'd1, 32'd0, 1'b0);
        step();
        chk("t6_b_wrap", order_b, 64'd0);
        chk("t6_b_insn1", 64'(insn_b), 64'h4000_0001);
        rec_i = mk(32'h4000_0003, 5'd1, 32'd0, 1'b0);
        step();
        rec_valid_i = 1'b0;
        chk("t6_b_issue", 64'(valid_b), 64'd1);
        chk("t6_b_count1", 64'(count_b), 64'd1);
        rst_ni = 1'b0;
        step();
        chk("t6_rst_valid", 64'(valid_b), 64'd0);
        chk("t6_rst_count", 64'(count_b), 64'd0);
        rst_ni = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
